sequenciador_contexto: RTL and testbench
========================================

# sequenciador_contexto

Context save/restore sequencer for the 32×32 register bank. When the OS layer switches processes, it moves the whole bank to or from a data-memory frame one word per clock. It sits between the register bank, the data memory and the CPU control unit. While busy it owns the bank's read port A, its write port and the data-memory port, and it stalls the CPU.

## Interface
- `NREG`, default 32: number of registers in a context frame. Fixed at 32 for this bank.
- `ADDR_W`, default 32: data-memory word-address width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; state cleared immediately while low.
- `inicio`  in  1  start request, sampled on rising edge when idle.
- `modo`  in  1  0 = save (bank→memory), 1 = restore (memory→bank); latched with `inicio`.
- `base`  in  ADDR_W  frame base word address; latched with `inicio`.
- `ocupado`  out  1  high while sequencing, including the FIM cycle; CPU hold and port-mux select.
- `fim`  out  1  one-cycle completion pulse.
- `reg_rd_idx`  out  5  drives the bank's read index A (combinational read).
- `reg_rd_dados`  in  32  bank read data A.
- `reg_wr_en`  out  1  bank write enable. The bank writes on the falling edge of the same cycle.
- `reg_wr_idx`  out  5  bank write index.
- `reg_wr_dados`  out  32  bank write data.
- `mem_addr`  out  ADDR_W  data-memory word address.
- `mem_wr_en`  out  1  data-memory write enable.
- `mem_wr_dados`  out  32  data-memory write data.
- `mem_rd_dados`  in  32  data-memory read data; synchronous read with 1-cycle latency.

## Operation
- States: OCIOSO, SALVA, RESTAURA, FIM.
- Counter `k`: 6 bits. Base register: ADDR_W bits.
- OCIOSO:
  - On `inicio`=1, latch `base` and `modo` and set k=0.
  - Go to SALVA if `modo`=0, otherwise RESTAURA.
- SALVA, cycle k = 0..31:
  - `reg_rd_idx`=k.
  - `mem_addr`=base+k.
  - `mem_wr_en`=1.
  - `mem_wr_dados`=`reg_rd_dados`, passed through combinationally with no register stage.
  - After k=31, go to FIM.
  - Frame layout: word base+i holds register i; all 32 registers are saved, r0 included.
- RESTAURA, cycle k = 0..31, a two-stage pipeline:
  - Read stage: for k ≤ 30, `mem_addr`=base+k+1, issuing reads of words 1..31.
  - Write stage: for k ≥ 1, `reg_wr_en`=1, `reg_wr_idx`=k, `reg_wr_dados`=`mem_rd_dados`.
  - r0 is never written.
  - After k=31, go to FIM.
- FIM: `fim`=1 for one cycle, then go to OCIOSO.
- Outputs when idle or in reset: `ocupado`=0, `fim`=0, `reg_wr_en`=0, `mem_wr_en`=0. All index, address and data outputs are 0.
- Enables are gated per state: `mem_wr_en` only in SALVA, `reg_wr_en` only in RESTAURA with k≥1. No write is ever issued in OCIOSO or FIM.
- Address arithmetic is ADDR_W-bit modulo. base+k wraps past all-ones with no error flag.
- `inicio` while `ocupado`=1 is ignored; it is neither queued nor restarted.
- `inicio` during the FIM cycle is also ignored. A new start is accepted from the first OCIOSO cycle.
- Changes on `base` or `modo` after the start edge have no effect on the running operation.
- Reset low mid-operation:
  - Return immediately to OCIOSO with all outputs at their reset values.
  - Writes already performed are not undone, and no `fim` is produced.

## Timing
- Start edge is E0; the state machine is busy on cycles 1..33.
- Save:
  - Memory writes in cycles 1..32 (word base+0 in cycle 1).
  - `fim` in cycle 33.
  - `ocupado` high cycles 1..33.
- Restore:
  - Memory reads issued in cycles 1..31.
  - Register writes r1..r31 in cycles 2..32.
  - `fim` in cycle 33.
- Both modes take exactly 33 cycles from start to `fim`.
- Back-to-back operation: with `inicio` held high, the next operation starts at the edge ending the first OCIOSO cycle. Minimum spacing is 34 cycles.
- Bank writes land on the falling edge within the same cycle. A save that immediately follows a restore reads the updated values.

## Test plan
- Save with bank r_i = 0xA5000000+i and base=0x100: memory words 0x100..0x11F = 0xA5000000..0xA500001F; `fim` on cycle 33; exactly 32 `mem_wr_en` cycles.
- Restore from a frame at base=0x200 holding 0x5A000000+i, with r0 preset to 0: r1..r31 = 0x5A000001..0x5A00001F; r0 = 0; exactly 31 `reg_wr_en` cycles.
- Round trip: save (base 0x300), scramble the bank, then restore (base 0x300): bank r1..r31 equal the originals; `ocupado` low for exactly one cycle between operations.
- `inicio` pulsed at cycle 10 of a save, with `modo`=1 and `base`=0x999 applied then: ignored; the save completes to 0x100..0x11F with a single `fim`.
- Wrap: base=0xFFFFFFF0 save writes 0xFFFFFFF0..0xFFFFFFFF, then 0x00000000..0x0000000F.
- Reset asserted at cycle 15 of a restore: outputs return to 0 immediately, there is no `fim`, and r14..r31 are unchanged; a new save after release runs the full 33 cycles.

Source files
------------

// File: rtl/sequenciador_contexto.sv
// Context save/restore sequencer: moves the whole 32-word register bank to
// or from a data-memory frame one word per clock, holding the CPU while busy.
module sequenciador_contexto #(
  parameter int NREG   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic              modo,
  input  logic [ADDR_W-1:0] base,
  output logic              ocupado,
  output logic              fim,
  output logic [4:0]        reg_rd_idx,
  input  logic [31:0]       reg_rd_dados,
  output logic              reg_wr_en,
  output logic [4:0]        reg_wr_idx,
  output logic [31:0]       reg_wr_dados,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_dados,
  input  logic [31:0]       mem_rd_dados
);

  typedef enum logic [1:0] {
    OCIOSO,
    SALVA,
    RESTAURA,
    FIM
  } state_t;

  localparam logic [5:0] K_LAST = 6'(NREG - 1);

  state_t            state, state_nxt;
  logic [5:0]        k, k_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;

  // State register, word counter and latched frame base.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= OCIOSO;
      k      <= '0;
      base_q <= '0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      base_q <= base_nxt;
    end
  end

  // Next-state logic; the direction (modo) is captured by the state chosen
  // at the start edge, so later changes on modo/base cannot leak in.
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    base_nxt  = base_q;
    unique case (state)
      OCIOSO: begin
        if (inicio) begin
          base_nxt  = base;
          k_nxt     = '0;
          state_nxt = modo ? RESTAURA : SALVA;
        end
      end
      SALVA, RESTAURA: begin
        if (k == K_LAST) state_nxt = FIM;
        else             k_nxt     = k + 6'd1;
      end
      FIM:     state_nxt = OCIOSO;
      default: state_nxt = OCIOSO;
    endcase
  end

  // Port drive per state; everything is zero outside the active states.
  // Restore runs a two-stage pipeline: cycle k issues the read of word k+1,
  // whose data arrives one cycle later and is written to register k+1.
  always_comb begin
    ocupado      = 1'b0;
    fim          = 1'b0;
    reg_rd_idx   = '0;
    reg_wr_en    = 1'b0;
    reg_wr_idx   = '0;
    reg_wr_dados = '0;
    mem_addr     = '0;
    mem_wr_en    = 1'b0;
    mem_wr_dados = '0;
    unique case (state)
      SALVA: begin
        ocupado      = 1'b1;
        reg_rd_idx   = k[4:0];
        mem_addr     = base_q + ADDR_W'(k);
        mem_wr_en    = 1'b1;
        mem_wr_dados = reg_rd_dados;
      end
      RESTAURA: begin
        ocupado = 1'b1;
        if (k != K_LAST) mem_addr = base_q + ADDR_W'(k) + ADDR_W'(1);
        // r0 is never loaded: word 0 of the frame is not read back.
        if (k != 6'd0) begin
          reg_wr_en    = 1'b1;
          reg_wr_idx   = k[4:0];
          reg_wr_dados = mem_rd_dados;
        end
      end
      FIM: begin
        ocupado = 1'b1;
        fim     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sequenciador_contexto.sv
// Bench for sequenciador_contexto: a register bank (falling-edge write,
// combinational read) and a sync-read data memory around the DUT, with
// expected frames/banks computed from plain loops over snapshots.
module tb_sequenciador_contexto;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio, modo;
  logic [31:0] base;
  logic        ocupado, fim, reg_wr_en, mem_wr_en;
  logic [4:0]  reg_rd_idx, reg_wr_idx;
  logic [31:0] reg_rd_dados, reg_wr_dados, mem_addr, mem_wr_dados;
  logic [31:0] mem_rd_dados;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bank [32];
  logic [31:0] mem  [logic [31:0]];

  sequenciador_contexto #(.NREG(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .modo(modo), .base(base),
    .ocupado(ocupado), .fim(fim),
    .reg_rd_idx(reg_rd_idx), .reg_rd_dados(reg_rd_dados),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_dados(reg_wr_dados),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_dados(mem_wr_dados),
    .mem_rd_dados(mem_rd_dados)
  );

  always #5 clk = ~clk;

  logic [109:0] outs_all;
  assign outs_all = {ocupado, fim, reg_wr_en, mem_wr_en, reg_rd_idx, reg_wr_idx,
                     reg_wr_dados, mem_addr, mem_wr_dados};

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  assign reg_rd_dados = bank[reg_rd_idx];

  always @(negedge clk) if (reg_wr_en) bank[reg_wr_idx] = reg_wr_dados;

  always @(posedge clk) begin
    mem_rd_dados <= mem_get(mem_addr);
    if (mem_wr_en) mem[mem_addr] = mem_wr_dados;
  end

  // Runs one operation from a start edge and counts what it observes over
  // 40 cycles. Optionally re-pulses inicio (with flipped modo, base 0x999)
  // at cycle pulse_cyc, or asserts reset at the start of cycle rst_cyc.
  task automatic run_op(input logic m, input logic [31:0] b, input int pulse_cyc,
                        input int rst_cyc, output int fim_cyc, output int nmw,
                        output int nrw, output int nfim, output int rst_bad);
    fim_cyc = 0; nmw = 0; nrw = 0; nfim = 0; rst_bad = 0;
    @(negedge clk);
    inicio = 1'b1; modo = m; base = b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) inicio = 1'b0;
      if (mem_wr_en) nmw++;
      if (reg_wr_en) nrw++;
      if (fim) begin
        nfim++;
        if (fim_cyc == 0) fim_cyc = n;
      end
      if (n == pulse_cyc) begin
        inicio = 1'b1; modo = ~m; base = 32'h999;
      end
      if (n == pulse_cyc + 1) inicio = 1'b0;
      if (rst_cyc != 0 && n == rst_cyc - 1) begin
        @(posedge clk);
        #1 reset = 1'b0;
        #1 if (outs_all !== '0) rst_bad = 1;
      end
      if (rst_cyc != 0 && n == rst_cyc + 2) reset = 1'b1;
    end
    inicio = 1'b0; modo = 1'b0; base = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; inicio = 1'b0; modo = 1'b0; base = '0;
    repeat (3) @(posedge clk);
    #1 n_checks++;
    if (outs_all !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", outs_all);
    end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs_all !== '0) begin
      n_fail++; $display("FAIL idle_outputs: got %h want 0", outs_all);
    end
  endtask

  task automatic test_save;
    int fc, nmw, nrw, nf, rb, bad;
    for (int i = 0; i < 32; i++) bank[i] = 32'hA500_0000 + 32'(i);
    mem.delete();
    run_op(1'b0, 32'h100, 0, 0, fc, nmw, nrw, nf, rb);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem_get(32'h100 + 32'(i)) !== 32'hA500_0000 + 32'(i)) bad++;
    n_checks++; if (fc != 33) begin n_fail++; $display("FAIL save_fim_cycle: got %0d want 33", fc); end
    n_checks++; if (nmw != 32) begin n_fail++; $display("FAIL save_mem_writes: got %0d want 32", nmw); end
    n_checks++; if (nrw != 0 || nf != 1) begin n_fail++; $display("FAIL save_regwr_fim: got %0d/%0d want 0/1", nrw, nf); end
    n_checks++; if (bad != 0 || mem.num() != 32) begin n_fail++; $display("FAIL save_frame: got %0d bad words, %0d written want 0, 32", bad, mem.num()); end
  endtask

  task automatic test_restore;
    int fc, nmw, nrw, nf, rb, bad;
    mem.delete();
    for (int i = 0; i < 32; i++) begin
      mem[32'h200 + 32'(i)] = 32'h5A00_0000 + 32'(i);
      bank[i] = $urandom;
    end
    bank[0] = '0;
    run_op(1'b1, 32'h200, 0, 0, fc, nmw, nrw, nf, rb);
    bad = 0;
    for (int i = 1; i < 32; i++) if (bank[i] !== 32'h5A00_0000 + 32'(i)) bad++;
    n_checks++; if (fc != 33) begin n_fail++; $display("FAIL restore_fim_cycle: got %0d want 33", fc); end
    n_checks++; if (nrw != 31 || nmw != 0) begin n_fail++; $display("FAIL restore_writes: got reg %0d mem %0d want 31/0", nrw, nmw); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL restore_bank: got %0d bad registers want 0", bad); end
    n_checks++; if (bank[0] !== 32'h0) begin n_fail++; $display("FAIL restore_r0: got %h want 0", bank[0]); end
  endtask

  // Save then restore back to back with inicio held high; the bank is
  // scrambled during the FIM cycle of the save.
  task automatic test_round_trip;
    logic [31:0] orig [32];
    logic [31:0] r0_scr;
    int fim1, fim2, low_cnt, bad;
    fim1 = 0; fim2 = 0; low_cnt = 0; r0_scr = '0;
    mem.delete();
    for (int i = 0; i < 32; i++) begin orig[i] = $urandom; bank[i] = orig[i]; end
    @(negedge clk);
    inicio = 1'b1; modo = 1'b0; base = 32'h300;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (fim1 != 0 && fim2 == 0 && !ocupado) low_cnt++;
      if (fim && fim1 == 0) begin
        fim1 = n;
        for (int i = 0; i < 32; i++) bank[i] = ~orig[i] ^ $urandom;
        r0_scr = bank[0];
        modo = 1'b1;
      end else if (fim && fim2 == 0) begin
        fim2 = n;
        inicio = 1'b0;
      end
    end
    inicio = 1'b0; modo = 1'b0; base = '0;
    bad = 0;
    for (int i = 1; i < 32; i++) if (bank[i] !== orig[i]) bad++;
    n_checks++; if (fim1 != 33 || fim2 != 67) begin n_fail++; $display("FAIL rt_fim_cycles: got %0d,%0d want 33,67", fim1, fim2); end
    n_checks++; if (low_cnt != 1) begin n_fail++; $display("FAIL rt_idle_gap: got %0d want 1", low_cnt); end
    n_checks++; if (bad != 0 || bank[0] !== r0_scr) begin n_fail++; $display("FAIL rt_bank: got %0d bad, r0 %h want 0, %h", bad, bank[0], r0_scr); end
  endtask

  task automatic test_ignore_inicio;
    int fc, nmw, nrw, nf, rb, bad;
    for (int i = 0; i < 32; i++) bank[i] = 32'hA500_0000 + 32'(i);
    mem.delete();
    run_op(1'b0, 32'h100, 10, 0, fc, nmw, nrw, nf, rb);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem_get(32'h100 + 32'(i)) !== 32'hA500_0000 + 32'(i)) bad++;
    n_checks++; if (nf != 1 || fc != 33) begin n_fail++; $display("FAIL ignore_fim: got %0d pulses at %0d want 1 at 33", nf, fc); end
    n_checks++; if (bad != 0 || nmw != 32 || nrw != 0) begin n_fail++; $display("FAIL ignore_frame: got bad %0d memwr %0d regwr %0d want 0/32/0", bad, nmw, nrw); end
    n_checks++; if (mem.exists(32'h999) || mem.exists(32'h99A)) begin n_fail++; $display("FAIL ignore_base: got write near 0x999 want none"); end
  endtask

  task automatic test_wrap;
    logic [31:0] snap [32];
    logic [31:0] a;
    int fc, nmw, nrw, nf, rb, bad;
    mem.delete();
    for (int i = 0; i < 32; i++) begin snap[i] = $urandom; bank[i] = snap[i]; end
    run_op(1'b0, 32'hFFFF_FFF0, 0, 0, fc, nmw, nrw, nf, rb);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      a = (i < 16) ? 32'hFFFF_FFF0 + 32'(i) : 32'(i - 16);
      if (mem_get(a) !== snap[i]) bad++;
    end
    n_checks++; if (bad != 0 || mem.num() != 32) begin n_fail++; $display("FAIL wrap_frame: got %0d bad, %0d words want 0, 32", bad, mem.num()); end
    n_checks++; if (fc != 33) begin n_fail++; $display("FAIL wrap_fim_cycle: got %0d want 33", fc); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] snap [32];
    int fc, nmw, nrw, nf, rb, bad;
    mem.delete();
    for (int i = 0; i < 32; i++) begin
      snap[i] = $urandom; bank[i] = snap[i];
      mem[32'h400 + 32'(i)] = $urandom;
    end
    run_op(1'b1, 32'h400, 0, 15, fc, nmw, nrw, nf, rb);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (bank[i] !== ((i >= 1 && i <= 13) ? mem_get(32'h400 + 32'(i)) : snap[i])) bad++;
    n_checks++; if (rb != 0) begin n_fail++; $display("FAIL rst_outputs: got nonzero outputs during reset want 0"); end
    n_checks++; if (nf != 0) begin n_fail++; $display("FAIL rst_no_fim: got %0d fim want 0", nf); end
    n_checks++; if (bad != 0 || nrw != 13) begin n_fail++; $display("FAIL rst_bank: got %0d bad, %0d writes want 0, 13", bad, nrw); end
    mem.delete();
    for (int i = 0; i < 32; i++) snap[i] = bank[i];
    run_op(1'b0, 32'h500, 0, 0, fc, nmw, nrw, nf, rb);
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem_get(32'h500 + 32'(i)) !== snap[i]) bad++;
    n_checks++; if (fc != 33 || nmw != 32 || bad != 0) begin n_fail++; $display("FAIL rst_resave: got fim %0d writes %0d bad %0d want 33/32/0", fc, nmw, bad); end
  endtask

  task automatic test_random;
    logic [31:0] snap [32];
    logic [31:0] b;
    logic        m;
    int fc, nmw, nrw, nf, rb, bad;
    for (int it = 0; it < 6; it++) begin
      m = 1'($urandom);
      b = (it % 2 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 40)) : $urandom;
      mem.delete();
      for (int i = 0; i < 32; i++) begin
        snap[i] = $urandom; bank[i] = snap[i];
        mem[b + 32'(i)] = $urandom;
      end
      run_op(m, b, 0, 0, fc, nmw, nrw, nf, rb);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (!m && mem_get(b + 32'(i)) !== snap[i]) bad++;
        if (m && bank[i] !== ((i == 0) ? snap[0] : mem_get(b + 32'(i)))) bad++;
      end
      n_checks++;
      if (bad != 0 || fc != 33 || nf != 1 || nmw != (m ? 0 : 32) || nrw != (m ? 31 : 0)) begin
        n_fail++;
        $display("FAIL random_op%0d: got modo %0d bad %0d fim %0d/%0d mw %0d rw %0d want 0 bad, fim 1 at 33",
                 it, m, bad, nf, fc, nmw, nrw);
      end
    end
  endtask

  initial begin
    test_reset;
    test_save;
    test_restore;
    test_round_trip;
    test_ignore_inicio;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
